// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 link types, frame constants and parity helper
package ps2_pkg;
  typedef enum logic [2:0] {IDLE, INHIBIT, SEND, ACK, WAITIDLE} ps2_state_t;
  localparam int FRAME_BITS = 11;
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction
endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: 2-FF synchronizer for ps2clk/ps2data with a one-cycle clock-fall strobe
module ps2_line_sync (
  input  logic clk,
  input  logic n_reset,
  input  logic line_clk,
  input  logic line_data,
  output logic sclk,
  output logic sdata,
  output logic fall
);
  logic [1:0] cm, dm;
  logic clk_d;
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      cm <= 2'b11;
      dm <= 2'b11;
      clk_d <= 1'b1;
    end else begin
      cm <= {cm[0], line_clk};
      dm <= {dm[0], line_data};
      clk_d <= cm[1];
    end
  end
  assign sclk = cm[1];
  assign sdata = dm[1];
  assign fall = clk_d & ~cm[1];
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 byte transmitter driving open-collector clk/data enables
module ps2_host_tx import ps2_pkg::*; #(
  parameter int clk_mhz = 25,
  parameter int inhibit_us = 100,
  parameter int timeout_us = 20000
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic [7:0] tx_data,
  input  logic       tx_strobe,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  output logic       rx_inhibit,
  input  logic       ps2clk_i,
  input  logic       ps2data_i,
  output logic       ps2clk_oe,
  output logic       ps2data_oe
);
  localparam int INH = clk_mhz * inhibit_us;
  localparam int WD = clk_mhz * timeout_us;
  localparam int IW = $clog2(INH + 1);
  localparam int WW = $clog2(WD + 1);
  logic sclk, sdata, fall;
  ps2_state_t state, state_n;
  logic [7:0] sh, sh_n;
  logic par, par_n;
  logic [3:0] n, n_n;
  logic [IW-1:0] inh, inh_n;
  logic [WW-1:0] wd, wd_n;
  logic busy_n, done_n, err_n, coe_n, doe_n;
  ps2_line_sync u_sync (
    .clk(clk),
    .n_reset(n_reset),
    .line_clk(ps2clk_i),
    .line_data(ps2data_i),
    .sclk(sclk),
    .sdata(sdata),
    .fall(fall)
  );
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state <= IDLE;
      sh <= '0;
      par <= 1'b0;
      n <= '0;
      inh <= '0;
      wd <= '0;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
      tx_error <= 1'b0;
      ps2clk_oe <= 1'b0;
      ps2data_oe <= 1'b0;
    end else begin
      state <= state_n;
      sh <= sh_n;
      par <= par_n;
      n <= n_n;
      inh <= inh_n;
      wd <= wd_n;
      tx_busy <= busy_n;
      tx_done <= done_n;
      tx_error <= err_n;
      ps2clk_oe <= coe_n;
      ps2data_oe <= doe_n;
    end
  end
  always_comb begin
    state_n = state;
    sh_n = sh;
    par_n = par;
    n_n = n;
    inh_n = (inh != '0) ? inh - 1'b1 : inh;
    wd_n = (wd != '0) ? wd - 1'b1 : wd;
    busy_n = tx_busy;
    done_n = 1'b0;
    err_n = 1'b0;
    coe_n = ps2clk_oe;
    doe_n = ps2data_oe;
    case (state)
      IDLE: if (tx_strobe) begin
        sh_n = tx_data;
        par_n = odd_parity(tx_data);
        busy_n = 1'b1;
        coe_n = 1'b1;
        inh_n = IW'(INH - 1);
        state_n = INHIBIT;
      end
      INHIBIT: begin
        if (inh <= IW'(1)) doe_n = 1'b1;
        if (inh == '0) begin
          coe_n = 1'b0;
          wd_n = WW'(WD - 1);
          n_n = '0;
          state_n = SEND;
        end
      end
      default: if (wd == '0) begin
        coe_n = 1'b0;
        doe_n = 1'b0;
        err_n = 1'b1;
        busy_n = 1'b0;
        state_n = IDLE;
      end else if (state == SEND) begin
        if (fall) begin
          n_n = n + 4'd1;
          doe_n = (n < 4'd8) ? ~sh[n[2:0]] : (n == 4'd8) ? ~par : 1'b0;
          if (n == 4'(FRAME_BITS - 2)) state_n = ACK;
        end
      end else if (state == ACK) begin
        if (fall) begin
          err_n = sdata;
          busy_n = ~sdata;
          state_n = sdata ? IDLE : WAITIDLE;
        end
      end else if (sclk && sdata) begin
        done_n = 1'b1;
        busy_n = 1'b0;
        state_n = IDLE;
      end
    endcase
  end
  assign rx_inhibit = tx_busy;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench with a PS/2 device model clocking the host frame
module tb_ps2_host_tx;
  localparam int H = 60;
  localparam int TIMEOUT_US = 400;
  localparam int WD = 25 * TIMEOUT_US;
  logic clk = 0, n_reset = 0, tx_strobe = 0;
  logic [7:0] tx_data = 0;
  logic dev_clk_low = 0, dev_data_low = 0;
  logic tx_busy, tx_done, tx_error, rx_inhibit, ps2clk_oe, ps2data_oe;
  logic bus_clk, bus_data;
  int checks = 0, errors = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0, track_err = 0, oe_len = 0;
  assign bus_clk = !(ps2clk_oe || dev_clk_low);
  assign bus_data = !(ps2data_oe || dev_data_low);
  ps2_host_tx #(.clk_mhz(25), .inhibit_us(100), .timeout_us(TIMEOUT_US)) dut (
    .clk(clk), .n_reset(n_reset), .tx_data(tx_data), .tx_strobe(tx_strobe),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_error(tx_error), .rx_inhibit(rx_inhibit),
    .ps2clk_i(bus_clk), .ps2data_i(bus_data), .ps2clk_oe(ps2clk_oe), .ps2data_oe(ps2data_oe)
  );
  always #20 clk = ~clk;
  always @(negedge clk) begin
    if (tx_done) done_cnt++;
    if (tx_error) err_cnt++;
    if (tx_done && tx_error) both_cnt++;
    if (rx_inhibit !== tx_busy) track_err++;
    if (ps2clk_oe) oe_len++;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic strobe(input logic [7:0] d);
    tx_data = d;
    tx_strobe = 1;
    @(negedge clk);
    tx_strobe = 0;
  endtask
  task automatic wait_req();
    for (int k = 0; k < 200 && !ps2clk_oe; k++) @(negedge clk);
    for (int k = 0; k < 4000 && ps2clk_oe; k++) @(negedge clk);
    check("request", {ps2clk_oe, ps2data_oe}, 2'b01);
  endtask
  task automatic clk_pulse(output logic b);
    repeat (H) @(negedge clk);
    dev_clk_low = 1;
    repeat (H) @(negedge clk);
    dev_clk_low = 0;
    b = bus_data;
  endtask
  task automatic device(input int falls, input bit ack, output logic [10:0] f);
    logic b;
    wait_req();
    f = '0;
    f[0] = bus_data;
    for (int i = 1; i <= falls && i <= 10; i++) begin
      clk_pulse(b);
      f[i] = b;
    end
    if (falls == 11) begin
      repeat (H / 2) @(negedge clk);
      dev_data_low = ack;
      clk_pulse(b);
      repeat (H / 2) @(negedge clk);
      dev_data_low = 0;
    end
  endtask
  task automatic finish_chk(input string tag, input int d0, input int e0, input int xd, input int xe);
    repeat (20) @(negedge clk);
    check({tag, "_done"}, done_cnt - d0, xd);
    check({tag, "_error"}, err_cnt - e0, xe);
    check({tag, "_idle"}, {tx_busy, ps2clk_oe, ps2data_oe}, 3'b000);
  endtask
  initial begin
    logic [10:0] f;
    int d0, e0, c;
    repeat (3) @(negedge clk);
    check("reset_outputs", {tx_busy, tx_done, tx_error, rx_inhibit, ps2clk_oe, ps2data_oe}, 6'b0);
    n_reset = 1;
    @(negedge clk);
    d0 = done_cnt; e0 = err_cnt; oe_len = 0;
    strobe(8'hED);
    check("busy_after_strobe", tx_busy, 1'b1);
    device(11, 1, f);
    check("inhibit_len", oe_len, 2500);
    check("frame_ed", f, 11'h7DA);
    finish_chk("ed", d0, e0, 1, 0);
    d0 = done_cnt; e0 = err_cnt;
    strobe(8'h01);
    device(11, 0, f);
    check("parity_01", f[9], 1'b0);
    check("frame_01", f, 11'h402);
    finish_chk("nack", d0, e0, 0, 1);
    d0 = done_cnt; e0 = err_cnt;
    strobe(8'hA5);
    wait_req();
    c = 0;
    while (!tx_error && c < WD + 100) begin
      @(negedge clk);
      c++;
    end
    check("watchdog_cycles", c, WD);
    check("watchdog_lines", {ps2clk_oe, ps2data_oe, tx_busy}, 3'b000);
    finish_chk("watchdog", d0, e0, 0, 1);
    d0 = done_cnt; e0 = err_cnt;
    strobe(8'hED);
    repeat (100) @(negedge clk);
    strobe(8'hFF);
    device(11, 1, f);
    check("frame_ignore_ff", f, 11'h7DA);
    finish_chk("ignore", d0, e0, 1, 0);
    d0 = done_cnt; e0 = err_cnt;
    strobe(8'hF4);
    device(4, 1, f);
    check("partial_f4", f[4:0], 5'h08);
    check("pre_reset", {tx_busy, ps2data_oe}, 2'b11);
    n_reset = 0;
    @(negedge clk);
    check("mid_reset", {ps2clk_oe, ps2data_oe, tx_busy, tx_done, tx_error}, 5'b0);
    n_reset = 1;
    finish_chk("reset", d0, e0, 0, 0);
    d0 = done_cnt; e0 = err_cnt;
    strobe(8'hF4);
    device(11, 1, f);
    check("frame_f4", f, 11'h5E8);
    finish_chk("f4", d0, e0, 1, 0);
    d0 = done_cnt; e0 = err_cnt;
    strobe(8'hED);
    device(11, 1, f);
    check("b2b_frame_ed", f, 11'h7DA);
    for (int k = 0; k < 100 && !tx_done; k++) @(negedge clk);
    check("b2b_done_seen", {tx_done, tx_busy}, 2'b10);
    strobe(8'h02);
    check("b2b_busy", tx_busy, 1'b1);
    device(11, 1, f);
    check("b2b_frame_02", f, 11'h404);
    finish_chk("b2b", d0, e0, 2, 0);
    check("done_error_overlap", both_cnt, 0);
    check("rx_inhibit_tracks", track_err, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
